alu_exec: RTL
=============

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width (only 32 is supported).
REQ-002 SHALL have ports, one clock and one asynchronous active-high reset:
  clk_i  input  1  rising-edge clock
  rst_i  input  1  reset, asynchronous, active-high
  start_i  input  1  request; accepted when busy_o low
  ctrl_i  input  4  operation code from ALU control stage
  src1_i  input  32  operand A (rs)
  src2_i  input  32  operand B (rt/immediate)
  shamt_i  input  5  shift amount for SRA
  busy_o  output  1  multi-cycle operation in progress
  done_o  output  1  result_o/hi_o/zero_o/overflow_o valid this cycle
  result_o  output  32  result (MULTU: low word)
  hi_o  output  32  MULTU high word
  zero_o  output  1  result_o == 0
  overflow_o  output  1  signed overflow for ADD/SUB

Function
REQ-003 SHALL decode ctrl_i: 0000 AND; 0001 OR; 0010 ADD; 0011 SUB; 0110 SUB (branch compare); 0111 SLT signed; 1011 SLTU; 0100 SRAV (src2 >>> src1[4:0]); 1111 SRA (src2 >>> shamt_i); 1010 LUI (src2[15:0] << 16); 1000 MULTU; all other codes produce result 0.
REQ-004 SHALL sample ctrl_i, src1_i, src2_i, shamt_i only in the accept cycle (start_i=1, busy_o=0); later input changes SHALL NOT affect the operation.
REQ-005 FSM states SHALL be IDLE, MUL, DONE.
REQ-006 IDLE or DONE + accepted non-MULTU -> DONE; result registered, done_o=1 in the cycle after accept (latency 1, throughput 1/cycle back-to-back).
REQ-007 IDLE or DONE + accepted MULTU -> MUL; busy_o=1; 5-bit counter from 0, one shift-add step per cycle (unsigned, 1 multiplier bit per cycle).
REQ-008 MUL -> DONE after the 32nd step; done_o=1 exactly 33 cycles after the accept cycle; result_o = product[31:0], hi_o = product[63:32].
REQ-009 DONE with no accept -> IDLE; done_o SHALL be a single-cycle pulse per operation.
REQ-010 start_i while busy_o=1 SHALL be ignored (no queuing, no effect on current operation).
REQ-011 result_o, zero_o, overflow_o SHALL hold their last values until the next done_o; hi_o SHALL change only on MULTU completion.
REQ-012 ADD/SUB SHALL wrap modulo 2^32; overflow_o = signed overflow; overflow_o=0 for all other ops.
REQ-013 SLT/SLTU SHALL return 32'h1 or 32'h0.
REQ-014 zero_o SHALL be registered together with result_o and equal (result_o == 0).
REQ-015 Unknown ctrl_i SHALL still complete in 1 cycle with result 0, zero_o=1, overflow_o=0.

Reset
REQ-016 rst_i high SHALL immediately force state IDLE, counter 0, busy_o=0, done_o=0, result_o=0, hi_o=0, zero_o=0, overflow_o=0, partial product cleared.
REQ-017 Reset during MUL SHALL abort the multiply; no done_o SHALL be produced for it.
REQ-018 First accept SHALL be possible in the first rising edge after rst_i deasserts.

Structure
REQ-019 Operation codes, FSM state encodings and DATA_W SHALL live in shared package alu_pkg, also used by the ALU control stage.
REQ-020 The iterative multiplier SHALL be sub-module mul_iter (start/done handshake, 32x32 -> 64 unsigned); combinational ops stay in alu_exec.

Verification
REQ-021 ADD 32'h7FFFFFFF + 32'h1 -> next cycle done_o=1, result_o=32'h80000000, overflow_o=1, zero_o=0.
REQ-022 SUB code 0110, 5 - 5 -> result_o=0, zero_o=1; then SLT -1 vs 1 -> 1; SLTU -1 vs 1 -> 0 on consecutive cycles, done_o high on each.
REQ-023 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> busy_o=1 for 32 cycles, done_o at accept+33, hi_o=32'hFFFFFFFE, result_o=32'h00000001; start_i pulses during busy ignored.
REQ-024 SRA src2=32'h80000000, shamt_i=4 -> 32'hF8000000; SRAV src1=31 same src2 -> 32'hFFFFFFFF; LUI src2=32'h1234 -> 32'h12340000.
REQ-025 Assert rst_i at MULTU step 10 -> outputs 0 immediately, no done_o; new ADD 2+3 after release -> result_o=5 at latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and the ALU control stage:
// datapath width, operation codes and execute FSM state encodings.
package alu_pkg;

  localparam int DATA_W = 32;

  // Operation codes produced by the ALU control stage
  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_ADD     = 4'b0010;
  localparam logic [3:0] OP_SUB     = 4'b0011;
  localparam logic [3:0] OP_SRAV    = 4'b0100;
  localparam logic [3:0] OP_BEQ_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT     = 4'b0111;
  localparam logic [3:0] OP_MULTU   = 4'b1000;
  localparam logic [3:0] OP_LUI     = 4'b1010;
  localparam logic [3:0] OP_SLTU    = 4'b1011;
  localparam logic [3:0] OP_SRA     = 4'b1111;

  // Execute FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Signed overflow of an addition, judged from the operand and sum sign bits.
  // Subtraction reuses it by passing the inverted sign of the subtrahend.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_exec_mul_iter.sv
// Iterative unsigned 32x32 -> 64 multiplier, one multiplier bit per cycle.
// The product register starts as {0, multiplier}; each step adds the
// multiplicand into the upper half when the current low bit is set, then
// shifts the whole register right by one. done and product are presented
// combinationally in the cycle of the final step so the parent can register
// the finished product on the same edge that performs that step.
module mul_iter
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                done,
  output logic [2*DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  logic                active;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   mcand;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W:0]     step_sum;
  logic [2*DATA_W-1:0] acc_next;

  // One shift-add step of the product register
  always_comb begin
    step_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_next = {step_sum, acc[DATA_W-1:1]};
  end

  assign done    = active && (cnt == LAST_STEP);
  assign product = acc_next;

  // Load operands on start, then step once per cycle until the last bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
    end else if (start && !active) begin
      active <= 1'b1;
      cnt    <= '0;
      mcand  <= a;
      acc    <= {{DATA_W{1'b0}}, b};
    end else if (active) begin
      acc <= acc_next;
      cnt <= cnt + 1'b1;
      if (cnt == LAST_STEP) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU. Single-cycle operations are evaluated from the inputs in
// the accept cycle and registered; MULTU is handed to the iterative
// multiplier and the FSM waits in MUL until it finishes. Outputs hold their
// last values between completions, and done_o pulses once per operation.
module alu_exec #(
  parameter int DATA_W = alu_pkg::DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [3:0]        ctrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [4:0]        shamt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] hi_o,
  output logic              zero_o,
  output logic              overflow_o
);

  import alu_pkg::*;

  logic [1:0]          state;
  logic                accept;
  logic                is_mul;
  logic [DATA_W-1:0]   sum;
  logic [DATA_W-1:0]   diff;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_ovf;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_product;

  assign busy_o = (state == ST_MUL);
  assign accept = start_i && !busy_o;
  assign is_mul = (ctrl_i == OP_MULTU);
  assign sum    = src1_i + src2_i;
  assign diff   = src1_i - src2_i;

  // Single-cycle operation decode; MULTU and unknown codes yield zero here
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ctrl_i)
      OP_AND:  alu_res = src1_i & src2_i;
      OP_OR:   alu_res = src1_i | src2_i;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = add_overflow(src1_i[DATA_W-1], src2_i[DATA_W-1], sum[DATA_W-1]);
      end
      OP_SUB, OP_BEQ_SUB: begin
        alu_res = diff;
        alu_ovf = add_overflow(src1_i[DATA_W-1], ~src2_i[DATA_W-1], diff[DATA_W-1]);
      end
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
      OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, src1_i < src2_i};
      OP_SRAV: alu_res = $unsigned($signed(src2_i) >>> src1_i[4:0]);
      OP_SRA:  alu_res = $unsigned($signed(src2_i) >>> shamt_i);
      OP_LUI:  alu_res = {src2_i[15:0], 16'h0000};
      default: alu_res = '0;
    endcase
  end

  mul_iter u_mul_iter (
    .clk     (clk_i),
    .rst     (rst_i),
    .start   (accept && is_mul),
    .a       (src1_i),
    .b       (src2_i),
    .done    (mul_done),
    .product (mul_product)
  );

  // Execute FSM and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      done_o     <= 1'b0;
      result_o   <= '0;
      hi_o       <= '0;
      zero_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept && is_mul) begin
            state <= ST_MUL;
          end else if (accept) begin
            state      <= ST_DONE;
            done_o     <= 1'b1;
            result_o   <= alu_res;
            zero_o     <= (alu_res == '0);
            overflow_o <= alu_ovf;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state      <= ST_DONE;
            done_o     <= 1'b1;
            result_o   <= mul_product[DATA_W-1:0];
            hi_o       <= mul_product[2*DATA_W-1:DATA_W];
            zero_o     <= (mul_product[DATA_W-1:0] == '0);
            overflow_o <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
